// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter that hands a shared tri-state bus to one of N_CH channels,
// with a fixed Z turnaround gap between owners and an optional hold limit.
module tristate_bus_arbiter #(
    parameter int WIDTH      = 8,
    parameter int N_CH       = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 4,
    localparam int OW        = $clog2(N_CH),
    localparam int BW        = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*WIDTH-1:0] data_in,
    output logic [N_CH-1:0]       grant,
    output logic [OW-1:0]         owner,
    output logic                  bus_oe,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_CH-1:0]  r_grant, w_grant_nxt;
    logic [OW-1:0]    r_owner, w_owner_nxt;
    logic             r_oe, w_oe_nxt;
    logic [OW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [BW-1:0]    r_beats, w_beats_nxt;
    logic [3:0]       r_turn_cnt, w_turn_cnt_nxt;

    logic [OW:0]      w_pick;
    logic             w_release;
    logic [WIDTH-1:0] w_owner_data;

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [OW:0] rr_pick(input logic [N_CH-1:0] r, input logic [OW-1:0] ptr);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_CH;
            if (r[idx]) res = {1'b1, OW'(idx)};
        end
        return res;
    endfunction

    assign w_pick = rr_pick(req, r_rr_ptr);

    // Hold limit only forces a release when someone else is actually waiting.
    assign w_release = !req[r_owner] ||
                       ((MAX_HOLD != 0) && (r_beats == BW'(MAX_HOLD)) && |(req & ~r_grant));

    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_owner == OW'(i)) w_owner_data = data_in[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_oe_nxt       = r_oe;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beats_nxt    = r_beats;
        w_turn_cnt_nxt = r_turn_cnt;
        case (r_state)
            IDLE, TURN: begin
                if (r_state == TURN && r_turn_cnt != 4'd0) begin
                    w_turn_cnt_nxt = r_turn_cnt - 4'd1;
                end else if (w_pick[OW]) begin
                    w_state_nxt = DRIVE;
                    w_grant_nxt = N_CH'(1) << w_pick[OW-1:0];
                    w_owner_nxt = w_pick[OW-1:0];
                    w_oe_nxt    = 1'b1;
                    w_beats_nxt = BW'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRIVE: begin
                if (w_release) begin
                    w_state_nxt    = TURN;
                    w_grant_nxt    = '0;
                    w_oe_nxt       = 1'b0;
                    w_rr_ptr_nxt   = (r_owner == OW'(N_CH - 1)) ? '0 : r_owner + 1'b1;
                    w_turn_cnt_nxt = 4'(TURNAROUND - 1);
                end else if (MAX_HOLD != 0 && r_beats != BW'(MAX_HOLD)) begin
                    w_beats_nxt = r_beats + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_oe       <= 1'b0;
            r_rr_ptr   <= '0;
            r_beats    <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_oe       <= w_oe_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beats    <= w_beats_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
        end
    end

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign bus_oe  = r_oe;
    assign busy    = (r_state != IDLE);
    assign bus_out = r_oe ? w_owner_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the bus outputs.
module tb_tristate_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        bus_oe;
    logic [7:0]  bus_out;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] o;
        logic       oe;
        logic [7:0] bus;
        logic       busy;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;

    logic [31:0] d0 = 32'h33A50F11;
    logic [7:0]  zz = 8'hzz;

    tristate_bus_arbiter #(.WIDTH(8), .N_CH(4), .TURNAROUND(1), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .grant(grant), .owner(owner), .bus_oe(bus_oe), .bus_out(bus_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive this cycle's inputs and queue what the outputs must show this cycle.
    task automatic step(input logic rv, input logic [3:0] rq, input logic [31:0] d,
                        input logic [3:0] g, input logic [1:0] o, input logic oe,
                        input logic [7:0] b, input logic bz, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst = rv; req = rq; data_in = d;
        x.g = g; x.o = o; x.oe = oe; x.bus = b; x.busy = bz; x.name = nm;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (grant !== e.g || owner !== e.o || bus_oe !== e.oe || bus_out !== e.bus || busy !== e.busy) begin
                fails++;
                $display("FAIL %s: got grant=%b owner=%0d oe=%b bus=%h busy=%b, want grant=%b owner=%0d oe=%b bus=%h busy=%b",
                         e.name, grant, owner, bus_oe, bus_out, busy, e.g, e.o, e.oe, e.bus, e.busy);
            end
            tests++;
            if (!($onehot0(grant) && (bus_oe == |grant))) begin
                fails++;
                $display("FAIL invariant(%s): grant=%b bus_oe=%b", e.name, grant, bus_oe);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch;
        rst = 1'b1; req = 4'b1111; data_in = d0;
        // Reset held for two edges with all channels requesting
        step(1, 4'b1111, d0, 4'b0000, 2'd0, 0, zz, 0, "reset1");
        step(0, 4'b0000, d0, 4'b0000, 2'd0, 0, zz, 0, "reset2");
        // Single owner ch2
        step(0, 4'b0100, d0, 4'b0000, 2'd0, 0, zz, 0, "idle");
        step(0, 4'b0100, d0, 4'b0100, 2'd2, 1, 8'hA5, 1, "ch2_grant");
        step(0, 4'b0000, d0, 4'b0100, 2'd2, 1, 8'hA5, 1, "ch2_droplow");
        step(0, 4'b0000, d0, 4'b0000, 2'd2, 0, zz, 1, "ch2_turn");
        step(0, 4'b0000, d0, 4'b0000, 2'd2, 0, zz, 0, "ch2_idle");
        step(1, 4'b0000, d0, 4'b0000, 2'd2, 0, zz, 0, "idle_hold_owner");
        step(0, 4'b1111, d0, 4'b0000, 2'd0, 0, zz, 0, "reset3");
        // Round-robin 0,1,2,3,0 with 4 beats and one Z cycle each
        for (int s = 0; s < 5; s++) begin
            ch = s % 4;
            for (int b = 0; b < 4; b++)
                step(0, 4'b1111, d0, 4'(1 << ch), 2'(ch), 1, d0[ch*8 +: 8], 1, "rr_drive");
            step(0, (s == 4) ? 4'b0001 : 4'b1111, d0, 4'b0000, 2'(ch), 0, zz, 1, "rr_turn");
        end
        // Sole requester keeps the bus past MAX_HOLD
        for (int k = 0; k < 10; k++)
            step(0, 4'b0001, d0, 4'b0001, 2'd0, 1, 8'h11, 1, "solo");
        step(0, 4'b1000, d0, 4'b0001, 2'd0, 1, 8'h11, 1, "solo_last");
        step(0, 4'b1000, d0, 4'b0000, 2'd0, 0, zz, 1, "turn_to3");
        // Reset while ch3 drives
        step(1, 4'b1001, d0, 4'b1000, 2'd3, 1, 8'h33, 1, "ch3_own");
        step(0, 4'b1001, d0, 4'b0000, 2'd0, 0, zz, 0, "rst_mid");
        step(0, 4'b0010, d0, 4'b0001, 2'd0, 1, 8'h11, 1, "rr_ptr0");
        step(0, 4'b0010, d0, 4'b0000, 2'd0, 0, zz, 1, "turn_to1");
        // Live data passthrough for ch1
        step(0, 4'b0010, d0, 4'b0010, 2'd1, 1, 8'h0F, 1, "ch1_own");
        step(0, 4'b0010, 32'h33A5F011, 4'b0010, 2'd1, 1, 8'hF0, 1, "live_data");
        step(0, 4'b0010, 32'hCC5AF0EE, 4'b0010, 2'd1, 1, 8'hF0, 1, "nonowner_data");
        step(0, 4'b0000, 32'hCC5AF0EE, 4'b0010, 2'd1, 1, 8'hF0, 1, "ch1_droplow");
        step(0, 4'b0000, 32'hCC5AF0EE, 4'b0000, 2'd1, 0, zz, 1, "ch1_turn");
        step(0, 4'b0000, 32'hCC5AF0EE, 4'b0000, 2'd1, 0, zz, 0, "ch1_idle");
        repeat (3) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
